// File: rtl/pipe_seg_adder.sv
// rtl/pipe_seg_adder.sv - segmented carry-pipelined adder, SEG bits per stage, valid/ready handshake
// Optional signed-overflow output: define PIPE_SEG_ADDER_OVF_EN.
module pipe_seg_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_SEG_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTG = WIDTH / SEG;

    logic adv;

    for (genvar k = 0; k < NSTG; k++) begin : gen_stg
        // Operand bits still to be added at this stage: segment k and above.
        localparam int UW = WIDTH - k * SEG;

        logic [UW-1:0]         a_in;
        logic [UW-1:0]         b_in;
        logic                  c_in;
        logic                  v_in;
        logic [SEG:0]          seg_sum;
        logic [(k+1)*SEG-1:0]  s_d;
        logic [(k+1)*SEG-1:0]  s_q;
        logic                  c_q;
        logic                  v_q;

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : gen_head
            assign a_in = a;
            assign b_in = b;
            assign c_in = cin;
            assign v_in = in_valid;
            assign s_d  = seg_sum[SEG-1:0];
        end else begin : gen_link
            assign a_in = gen_stg[k-1].gen_fwd.a_q;
            assign b_in = gen_stg[k-1].gen_fwd.b_q;
            assign c_in = gen_stg[k-1].c_q;
            assign v_in = gen_stg[k-1].v_q;
            assign s_d  = {seg_sum[SEG-1:0], gen_stg[k-1].s_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= seg_sum[SEG];
                v_q <= v_in;
            end
        end

        // Skew register: upper operand bits travel alongside their partial sum.
        if (k < NSTG - 1) begin : gen_fwd
            logic [UW-SEG-1:0] a_q;
            logic [UW-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[UW-1:SEG];
                    b_q <= b_in[UW-1:SEG];
                end
            end
        end
    end

    // One global stall: every stage moves together, so bubbles are preserved.
    assign adv       = !gen_stg[NSTG-1].v_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = gen_stg[NSTG-1].v_q;
    assign sum       = gen_stg[NSTG-1].s_q;
    assign cout      = gen_stg[NSTG-1].c_q;

`ifdef PIPE_SEG_ADDER_OVF_EN
    logic msb_carry;
    logic ovf_q;

    // Carry into the MSB recovered from the MSB operand bits and sum bit.
    assign msb_carry = gen_stg[NSTG-1].a_in[SEG-1] ^ gen_stg[NSTG-1].b_in[SEG-1]
                     ^ gen_stg[NSTG-1].seg_sum[SEG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= msb_carry ^ gen_stg[NSTG-1].seg_sum[SEG];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_seg_adder.sv
// tb/tb_pipe_seg_adder.sv - randomized self-checking bench for pipe_seg_adder (WIDTH=64, SEG=8)
module tb_pipe_seg_adder;

    localparam int W    = 64;
    localparam int NSTG = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_SEG_ADDER_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    pipe_seg_adder #(.WIDTH(W), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_SEG_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    res_t q[$];
    res_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pops = 0;
    int   first_pop = 0;
    int   last_pop = 0;
    bit   mark_first = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        res_t     r;
        logic [W:0] t;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b0, {(W-1){1'b1}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: outputs popped in order, inputs pushed on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("sum", sum, e.s);
                    check("cout", {63'd0, cout}, {63'd0, e.c});
`ifdef PIPE_SEG_ADDER_OVF_EN
                    check("ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
                    pops++;
                    if (mark_first) begin
                        first_pop  = cyc;
                        mark_first = 0;
                    end
                    last_pop = cyc;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        bit r;
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic lat_check(input string tag);
        int n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, NSTG);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        int           base;
        logic [W-1:0] cs;
        logic         cc;

        #12;
        check("rst_out_valid", {63'd0, out_valid}, 0);
        check("rst_in_ready", {63'd0, in_ready}, 1);
        check("rst_sum", sum, 0);
        check("rst_cout", {63'd0, cout}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(64'h0000_0000_0000_00FF, 64'd1, 1'b0);
        in_valid = 1'b0;
        lat_check("lat_ff");
        check("ff_sum", sum, 64'h100);
        check("ff_cout", {63'd0, cout}, 0);
        drain();

        send('1, 64'd0, 1'b1);
        in_valid = 1'b0;
        lat_check("lat_wrap");
        check("wrap_sum", sum, 0);
        check("wrap_cout", {63'd0, cout}, 1);
        drain();

`ifdef PIPE_SEG_ADDER_OVF_EN
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        in_valid = 1'b0;
        lat_check("lat_ovf1");
        check("ovf_pos", {63'd0, ovf}, 1);
        check("ovf_pos_cout", {63'd0, cout}, 0);
        drain();
        send('1, 64'd1, 1'b0);
        in_valid = 1'b0;
        lat_check("lat_ovf0");
        check("ovf_neg", {63'd0, ovf}, 0);
        check("ovf_neg_cout", {63'd0, cout}, 1);
        drain();
`endif

        base       = pops;
        mark_first = 1;
        for (int i = 0; i < 20; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        drain();
        check("stream_count", pops - base, 20);
        check("stream_consec", last_pop - first_pop, 19);

        base      = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        a        = rnd();
        in_valid = 1'b1;
        cs       = sum;
        cc       = cout;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {63'd0, out_valid}, 1);
            check("stall_sum", sum, cs);
            check("stall_cout", {63'd0, cout}, {63'd0, cc});
            check("stall_ready", {63'd0, in_ready}, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("stall_count", pops - base, 3);

        for (int i = 0; i < 12; i++) send(rnd(), rnd(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        check("pre_rst_valid", {63'd0, out_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_ready", {63'd0, in_ready}, 1);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        base = pops;
        repeat (15) @(posedge clk);
        #1;
        check("no_stale", pops - base, 0);
        send(rnd(), rnd(), 1'b1);
        in_valid = 1'b0;
        lat_check("lat_after_rst");
        drain();

        base = pops;
        for (int i = 0; i < 300; i++) begin
            a         = rnd();
            b         = rnd();
            cin       = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("random_nonzero", (pops - base) > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
